// File: rtl/ipg_req_packer.sv
// Purpose: packs read/write requests into 64-bit chunks (header, payload, optional checksum) for the PHY request queue.
// Latency: header appears on ipg_req_chunk 2 cycles after request acceptance; each payload beat 1 cycle after its acceptance.
// Backpressure: tx_pause freezes emission and drops req_ready/wdata_ready; a stalled wdata_valid stalls DATA indefinitely.
// Optional feature: define IPG_REQ_CSUM_EN to append a running-XOR checksum chunk after each packet.
// Only DATA_WIDTH=64 and ADDR_WIDTH=48 are meaningful: the header layout is fixed to those widths.

module ipg_req_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_opcode,
  input  logic [3:0]            req_len,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic                  tx_pause,
  output logic [DATA_WIDTH-1:0] ipg_req_chunk,
  output logic                  reqq_write,
  output logic                  busy,
  output logic [7:0]            seq_num
);

  // Header word layout as it goes onto the request queue.
  typedef struct packed {
    logic [3:0]  kind;   // 1 = read, 2 = write
    logic [3:0]  len;
    logic [7:0]  seq;
    logic [47:0] addr;
  } hdr_t;

`ifdef IPG_REQ_CSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;
  // Every packet finishes with a checksum chunk.
  localparam state_t PKT_END = CSUM;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;
  // Packets end right after the last header/payload chunk.
  localparam state_t PKT_END = IDLE;
`endif

  state_t                state_q;
  logic                  op_q;       // latched opcode, 1 = write
  logic [3:0]            len_q;      // latched chunk count
  logic [ADDR_WIDTH-1:0] addr_q;     // latched remote address
  logic [7:0]            hdr_seq_q;  // sequence number stamped into this packet
  logic [7:0]            seq_num_q;  // sequence number for the next request
  logic [3:0]            beats_q;    // payload beats still expected
  logic [DATA_WIDTH-1:0] chunk_q;
  logic                  write_q;
`ifdef IPG_REQ_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;     // running XOR of header and payload
`endif

  hdr_t hdr;
  logic has_payload;
  logic beat_take;

  // Assemble the header from the latched request fields.
  always_comb begin
    hdr      = '0;
    hdr.kind = op_q ? 4'h2 : 4'h1;
    hdr.len  = len_q;
    hdr.seq  = hdr_seq_q;
    hdr.addr = addr_q;
  end

  // Handshakes are combinational so a request or beat can be taken every cycle;
  // both are forced low while reset is asserted.
  assign req_ready   = rst_n && (state_q == IDLE) && !tx_pause;
  assign wdata_ready = rst_n && (state_q == DATA) && !tx_pause;
  assign beat_take   = wdata_valid && wdata_ready;

  // Only writes with a non-zero length carry payload; reads are header-only.
  assign has_payload = op_q && (len_q != 4'd0);

  assign ipg_req_chunk = chunk_q;
  assign reqq_write    = write_q;
  assign seq_num       = seq_num_q;
  assign busy          = (state_q != IDLE);

  // Packet sequencer: latches requests, emits header/payload/checksum chunks as
  // registered one-cycle pulses and holds the chunk value between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      len_q     <= 4'd0;
      addr_q    <= '0;
      hdr_seq_q <= 8'd0;
      seq_num_q <= 8'd0;
      beats_q   <= 4'd0;
      chunk_q   <= '0;
      write_q   <= 1'b0;
`ifdef IPG_REQ_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      // Default: no chunk this cycle; chunk_q keeps its last value.
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_opcode;
            len_q     <= req_len;
            addr_q    <= req_addr;
            hdr_seq_q <= seq_num_q;
            seq_num_q <= seq_num_q + 8'd1;
            state_q   <= HDR;
          end
        end
        HDR: begin
          if (!tx_pause) begin
            chunk_q <= hdr;
            write_q <= 1'b1;
            beats_q <= has_payload ? len_q : 4'd0;
`ifdef IPG_REQ_CSUM_EN
            csum_q  <= hdr;
`endif
            state_q <= has_payload ? DATA : PKT_END;
          end
        end
        DATA: begin
          if (beat_take) begin
            chunk_q <= wdata;
            write_q <= 1'b1;
            beats_q <= beats_q - 4'd1;
`ifdef IPG_REQ_CSUM_EN
            csum_q  <= csum_q ^ wdata;
`endif
            if (beats_q == 4'd1) begin
              state_q <= PKT_END;
            end
          end
        end
`ifdef IPG_REQ_CSUM_EN
        CSUM: begin
          if (!tx_pause) begin
            chunk_q <= csum_q;
            write_q <= 1'b1;
            state_q <= IDLE;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipg_req_packer.sv
// Purpose: directed self-checking bench for ipg_req_packer (header/payload/checksum framing).
// Latency: inputs driven 1 ns after each rising edge, outputs checked at the same point.
// Backpressure: exercises tx_pause in HDR and DATA plus a reset in the middle of a packet.

module tb_ipg_req_packer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_opcode;
  logic [3:0]  req_len;
  logic [47:0] req_addr;
  logic [63:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic        tx_pause;
  logic [63:0] ipg_req_chunk;
  logic        reqq_write;
  logic        busy;
  logic [7:0]  seq_num;

  int checks = 0;
  int errors = 0;
  logic [63:0] wq[$];

  ipg_req_packer #(.DATA_WIDTH(64), .ADDR_WIDTH(48)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_len       (req_len),
    .req_addr      (req_addr),
    .wdata         (wdata),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .tx_pause      (tx_pause),
    .ipg_req_chunk (ipg_req_chunk),
    .reqq_write    (reqq_write),
    .busy          (busy),
    .seq_num       (seq_num)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every emitted chunk, sampled mid-cycle.
  always @(negedge clk) begin
    if (reqq_write) wq.push_back(ipg_req_chunk);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc;
    int bad;
    int stride;
    int exp_n;
    logic acc_now;
    logic [7:0] s;
    logic [63:0] h;

`ifdef IPG_REQ_CSUM_EN
    stride = 2;
`else
    stride = 1;
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_opcode = 1'b0; req_len = 4'd0;
    req_addr = 48'h0; wdata = 64'h0; wdata_valid = 1'b0; tx_pause = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_reqq_write", 64'(reqq_write), 64'd0);
    check("rst_chunk", ipg_req_chunk, 64'd0);
    check("rst_seq", 64'(seq_num), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_wdata_ready", 64'(wdata_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- read, len=4, seq 0 ----
    req_valid = 1'b1; req_opcode = 1'b0; req_len = 4'd4; req_addr = 48'h0000_1234_5678;
    #1;
    check("rd_req_ready", 64'(req_ready), 64'd1);
    tick();                                   // acceptance edge
    req_valid = 1'b0; req_addr = 48'hFFFF_FFFF_FFFF;
    check("rd_lat1_write", 64'(reqq_write), 64'd0);
    check("rd_busy", 64'(busy), 64'd1);
    check("rd_seq_inc", 64'(seq_num), 64'd1);
    check("rd_req_ready_busy", 64'(req_ready), 64'd0);
    tick();                                   // header edge
    check("rd_lat2_write", 64'(reqq_write), 64'd1);
    check("rd_hdr", ipg_req_chunk, 64'h1400_0000_1234_5678);
`ifdef IPG_REQ_CSUM_EN
    tick();
    check("rd_csum_write", 64'(reqq_write), 64'd1);
    check("rd_csum", ipg_req_chunk, 64'h1400_0000_1234_5678);
`endif
    tick();
    check("rd_pulse_end", 64'(reqq_write), 64'd0);
    check("rd_chunk_hold", ipg_req_chunk, 64'h1400_0000_1234_5678);
    check("rd_idle", 64'(busy), 64'd0);

    // ---- reset so the write starts at seq 0 ----
    rst_n = 1'b0;
    tick();
    check("rst2_seq", 64'(seq_num), 64'd0);
    rst_n = 1'b1;

    // ---- write, len=2, addr A0 ----
    req_valid = 1'b1; req_opcode = 1'b1; req_len = 4'd2; req_addr = 48'hA0;
    wdata = 64'h1111; wdata_valid = 1'b1;
    tick();                                   // accept
    req_valid = 1'b0; req_opcode = 1'b0; req_len = 4'd9;
    check("wr_no_early_beat", 64'(reqq_write), 64'd0);
    tick();                                   // header
    check("wr_hdr_write", 64'(reqq_write), 64'd1);
    check("wr_hdr", ipg_req_chunk, 64'h2200_0000_0000_00A0);
    check("wr_wdata_ready", 64'(wdata_ready), 64'd1);
    tick();
    check("wr_b0_write", 64'(reqq_write), 64'd1);
    check("wr_b0", ipg_req_chunk, 64'h1111);
    wdata = 64'h2222;
    tick();
    check("wr_b1_write", 64'(reqq_write), 64'd1);
    check("wr_b1", ipg_req_chunk, 64'h2222);
    wdata_valid = 1'b0;
    tick();
`ifdef IPG_REQ_CSUM_EN
    check("wr_csum_write", 64'(reqq_write), 64'd1);
    check("wr_csum", ipg_req_chunk, 64'h2200_0000_0000_3393);
    tick();
`endif
    check("wr_done_write", 64'(reqq_write), 64'd0);
    check("wr_done_busy", 64'(busy), 64'd0);

    // ---- write len=4 with tx_pause in HDR and 5 cycles in DATA, seq 1 ----
    wq.delete();
    req_valid = 1'b1; req_opcode = 1'b1; req_len = 4'd4; req_addr = 48'h100;
    wdata = 64'hAAA1; wdata_valid = 1'b1;
    tick();                                   // accept
    req_valid = 1'b0;
    tx_pause = 1'b1;
    tick();                                   // HDR held by pause
    check("ps_hdr_held", 64'(reqq_write), 64'd0);
    check("ps_hdr_busy", 64'(busy), 64'd1);
    tx_pause = 1'b0;
    tick();
    check("ps_hdr", ipg_req_chunk, 64'h2401_0000_0000_0100);
    tick();
    check("ps_b0", ipg_req_chunk, 64'hAAA1);
    wdata = 64'hAAA2;
    tx_pause = 1'b1;
    #1;
    check("ps_wdata_ready_low", 64'(wdata_ready), 64'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (reqq_write !== 1'b0) bad++;
      if (i < 4 && wdata_ready !== 1'b0) bad++;
    end
    check("ps_quiet_5", 64'(bad), 64'd0);
    tx_pause = 1'b0;
    tick();
    check("ps_b1", ipg_req_chunk, 64'hAAA2);
    wdata = 64'hAAA3;
    tick();
    check("ps_b2", ipg_req_chunk, 64'hAAA3);
    wdata = 64'hAAA4;
    tick();
    check("ps_b3", ipg_req_chunk, 64'hAAA4);
    wdata_valid = 1'b0;
    repeat (4) tick();
    exp_n = 5 + stride - 1;
    check("ps_chunk_count", 64'(wq.size()), 64'(exp_n));
    if (wq.size() >= 5) begin
      check("ps_q1", wq[1], 64'hAAA1);
      check("ps_q4", wq[4], 64'hAAA4);
    end

    // ---- 257 back-to-back reads, seq starts at 2 ----
    wq.delete();
    n_acc = 0;
    req_valid = 1'b1; req_opcode = 1'b0; req_len = 4'd0; req_addr = 48'h0;
    for (int c = 0; c < 3000 && n_acc < 257; c++) begin
      #1;
      acc_now = req_valid && req_ready;
      tick();
      if (acc_now) n_acc++;
      if (n_acc == 257) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check("b2b_accepted", 64'(n_acc), 64'd257);
    repeat (6) tick();
    check("b2b_count", 64'(wq.size()), 64'(257 * stride));
    check("b2b_seq_after", 64'(seq_num), 64'd3);
    bad = 0;
    if (wq.size() == 257 * stride) begin
      for (int k = 0; k < 257; k++) begin
        s = 8'(2 + k);
        h = {4'h1, 4'h0, s, 48'h0};
        if (wq[k * stride] !== h) bad++;
        if (stride == 2 && wq[k * stride + 1] !== h) bad++;
      end
      check("b2b_seq_ff", wq[253 * stride], 64'h10FF_0000_0000_0000);
      check("b2b_seq_wrap", wq[254 * stride], 64'h1000_0000_0000_0000);
    end
    check("b2b_all_headers", 64'(bad), 64'd0);

    // ---- reset after first payload beat of a len=8 write, seq 3 ----
    req_valid = 1'b1; req_opcode = 1'b1; req_len = 4'd8; req_addr = 48'h200;
    wdata = 64'hBEEF; wdata_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("mr_hdr", ipg_req_chunk, 64'h2803_0000_0000_0200);
    tick();
    check("mr_b0", ipg_req_chunk, 64'hBEEF);
    rst_n = 1'b0;
    #1;
    check("mr_wdata_ready_rst", 64'(wdata_ready), 64'd0);
    check("mr_req_ready_rst", 64'(req_ready), 64'd0);
    tick();
    check("mr_write", 64'(reqq_write), 64'd0);
    check("mr_seq", 64'(seq_num), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_chunk", ipg_req_chunk, 64'd0);
    rst_n = 1'b1;
    wq.delete();
    repeat (10) tick();
    check("mr_no_more_chunks", 64'(wq.size()), 64'd0);
    check("mr_idle", 64'(busy), 64'd0);
    check("mr_req_ready", 64'(req_ready), 64'd1);
    wdata_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
